// File: rtl/turn_controller.sv
// Attack-phase sequencer for the two 5x5 boards: reads the target cell, writes
// the hit/miss marker back and maintains both ships-left counters.
module turn_controller #(
  parameter int BOARD_N   = 5,
  parameter int PC_DELAY  = 8,
  parameter int MAX_RETRY = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       player_turn_State_i,
  input  logic       pc_turn_State_i,
  input  logic       fire_button_i,
  input  logic [2:0] i_actual_i,
  input  logic [2:0] j_actual_i,
  input  logic [2:0] i_random_i,
  input  logic [2:0] j_random_i,
  input  logic [2:0] ship_amount_define_i,
  input  logic       load_counts_i,
  output logic       rd_board_o,
  output logic [2:0] rd_i_o,
  output logic [2:0] rd_j_o,
  input  logic [1:0] rd_data_i,
  output logic       wr_en_o,
  output logic       wr_board_o,
  output logic [2:0] wr_i_o,
  output logic [2:0] wr_j_o,
  output logic [1:0] wr_data_o,
  output logic       player_has_move_o,
  output logic       pc_has_move_o,
  output logic       pc_ships_zero_o,
  output logic       player_ships_zero_o,
  output logic [2:0] pc_ships_left_o,
  output logic [2:0] player_ships_left_o,
  output logic       last_hit_o,
  output logic       shot_rejected_o,
  output logic       busy_o
);

  localparam int DW = (PC_DELAY > 1) ? $clog2(PC_DELAY) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [2:0] LAST = 3'(BOARD_N - 1);

  typedef enum logic [2:0] {
    IDLE, P_READ, P_EVAL, P_DONE, PC_WAIT, PC_READ, PC_EVAL, PC_DONE
  } state_t;

  state_t         state_q;
  logic           fire_prev_q, fire_edge_q, served_q, loaded_q, scan_q;
  logic [DW-1:0]  delay_q;
  logic [RW-1:0]  retry_q;
  logic [2:0]     pc_cnt_q, pl_cnt_q;
  logic           rd_board_q, wr_en_q, wr_board_q;
  logic [2:0]     rd_i_q, rd_j_q, wr_i_q, wr_j_q;
  logic [1:0]     wr_data_q;
  logic           player_move_q, pc_move_q, pc_zero_q, pl_zero_q;
  logic           last_hit_q, rejected_q;

  logic           fire_edge_d, player_ok_d, pc_ok_d;
  logic [2:0]     load_val_d, pc_dec_d, pl_dec_d;

  assign fire_edge_d = fire_button_i & ~fire_prev_q;
  assign player_ok_d = ({1'b0, i_actual_i} < 4'(BOARD_N)) && ({1'b0, j_actual_i} < 4'(BOARD_N));
  assign pc_ok_d     = (rd_i_q <= LAST) && (rd_j_q <= LAST);
  assign load_val_d  = (ship_amount_define_i > 3'd5) ? 3'd5 : ship_amount_define_i;
  assign pc_dec_d    = (pc_cnt_q == 3'd0) ? 3'd0 : pc_cnt_q - 3'd1;
  assign pl_dec_d    = (pl_cnt_q == 3'd0) ? 3'd0 : pl_cnt_q - 3'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      fire_prev_q   <= 1'b1;
      fire_edge_q   <= 1'b0;
      served_q      <= 1'b0;
      loaded_q      <= 1'b0;
      scan_q        <= 1'b0;
      delay_q       <= '0;
      retry_q       <= '0;
      pc_cnt_q      <= 3'd0;
      pl_cnt_q      <= 3'd0;
      rd_board_q    <= 1'b0;
      rd_i_q        <= 3'd0;
      rd_j_q        <= 3'd0;
      wr_en_q       <= 1'b0;
      wr_board_q    <= 1'b0;
      wr_i_q        <= 3'd0;
      wr_j_q        <= 3'd0;
      wr_data_q     <= 2'b00;
      player_move_q <= 1'b0;
      pc_move_q     <= 1'b0;
      pc_zero_q     <= 1'b0;
      pl_zero_q     <= 1'b0;
      last_hit_q    <= 1'b0;
      rejected_q    <= 1'b0;
    end else begin
      fire_prev_q   <= fire_button_i;
      fire_edge_q   <= fire_edge_d;
      wr_en_q       <= 1'b0;
      player_move_q <= 1'b0;
      pc_move_q     <= 1'b0;
      rejected_q    <= 1'b0;
      pc_zero_q     <= loaded_q && (pc_cnt_q == 3'd0);
      pl_zero_q     <= loaded_q && (pl_cnt_q == 3'd0);
      if (!pc_turn_State_i) served_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (player_turn_State_i && !pc_turn_State_i && fire_edge_q) begin
            if (!player_ok_d) begin
              rejected_q <= 1'b1;
            end else begin
              rd_board_q <= 1'b1;
              rd_i_q     <= i_actual_i;
              rd_j_q     <= j_actual_i;
              state_q    <= P_READ;
            end
          end else if (pc_turn_State_i && !served_q) begin
            delay_q <= DW'(PC_DELAY - 1);
            state_q <= PC_WAIT;
          end
        end
        P_READ: state_q <= P_EVAL;
        P_EVAL: begin
          if (rd_data_i[1]) begin
            rejected_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            wr_en_q    <= 1'b1;
            wr_board_q <= 1'b1;
            wr_i_q     <= rd_i_q;
            wr_j_q     <= rd_j_q;
            wr_data_q  <= {1'b1, rd_data_i[0]};
            last_hit_q <= rd_data_i[0];
            if (rd_data_i[0]) pc_cnt_q <= pc_dec_d;
            state_q    <= P_DONE;
          end
        end
        P_DONE: begin
          player_move_q <= 1'b1;
          state_q       <= IDLE;
        end
        PC_WAIT: begin
          if (delay_q == '0) begin
            rd_board_q <= 1'b0;
            rd_i_q     <= i_random_i;
            rd_j_q     <= j_random_i;
            retry_q    <= '0;
            scan_q     <= 1'b0;
            state_q    <= PC_READ;
          end else begin
            delay_q <= delay_q - DW'(1);
          end
        end
        PC_READ: state_q <= PC_EVAL;
        // Out-of-range random coordinates are rejected like an already-shot cell.
        PC_EVAL: begin
          if (pc_ok_d && !rd_data_i[1]) begin
            wr_en_q    <= 1'b1;
            wr_board_q <= 1'b0;
            wr_i_q     <= rd_i_q;
            wr_j_q     <= rd_j_q;
            wr_data_q  <= {1'b1, rd_data_i[0]};
            last_hit_q <= rd_data_i[0];
            if (rd_data_i[0]) pl_cnt_q <= pl_dec_d;
            state_q    <= PC_DONE;
          end else if (!scan_q) begin
            retry_q <= retry_q + RW'(1);
            if (retry_q == RW'(MAX_RETRY - 1)) begin
              scan_q <= 1'b1;
              rd_i_q <= 3'd0;
              rd_j_q <= 3'd0;
            end else begin
              rd_i_q <= i_random_i;
              rd_j_q <= j_random_i;
            end
            state_q <= PC_READ;
          end else if (rd_j_q == LAST) begin
            if (rd_i_q == LAST) begin
              state_q <= PC_DONE;
            end else begin
              rd_i_q  <= rd_i_q + 3'd1;
              rd_j_q  <= 3'd0;
              state_q <= PC_READ;
            end
          end else begin
            rd_j_q  <= rd_j_q + 3'd1;
            state_q <= PC_READ;
          end
        end
        PC_DONE: begin
          pc_move_q <= 1'b1;
          served_q  <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A load wins over any decrement issued in the same cycle.
      if (load_counts_i) begin
        pc_cnt_q <= load_val_d;
        pl_cnt_q <= load_val_d;
        loaded_q <= 1'b1;
      end
    end
  end

  assign rd_board_o          = rd_board_q;
  assign rd_i_o              = rd_i_q;
  assign rd_j_o              = rd_j_q;
  assign wr_en_o             = wr_en_q;
  assign wr_board_o          = wr_board_q;
  assign wr_i_o              = wr_i_q;
  assign wr_j_o              = wr_j_q;
  assign wr_data_o           = wr_data_q;
  assign player_has_move_o   = player_move_q;
  assign pc_has_move_o       = pc_move_q;
  assign pc_ships_zero_o     = pc_zero_q;
  assign player_ships_zero_o = pl_zero_q;
  assign pc_ships_left_o     = pc_cnt_q;
  assign player_ships_left_o = pl_cnt_q;
  assign last_hit_o          = last_hit_q;
  assign shot_rejected_o     = rejected_q;
  assign busy_o              = (state_q != IDLE);

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: a behavioural board/counter model
// predicts every shot outcome and its timing from the game rules.
module tb_turn_controller;

   localparam int N = 5;
   localparam int D = 8;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst, playerTurnState, pcTurnState, fireButton, loadCounts;
   logic [2:0] iActual, jActual, iRandom, jRandom, shipAmount;
   logic rdBoard, wrEn, wrBoard;
   logic [2:0] rdI, rdJ, wrI, wrJ;
   logic [1:0] rdData, wrData;
   logic playerHasMove, pcHasMove, pcShipsZero, playerShipsZero, lastHit, shotRejected, busy;
   logic [2:0] pcShipsLeft, playerShipsLeft;
   logic [29:0] allOut;

   int vectors = 0;
   int miscompares = 0;

   // observation record of the most recent window
   int wrCount, wrCycle, pmCount, pmCycle, pcmCount, pcmCycle, rejCount;
   logic wrB;
   logic [2:0] wrI_s, wrJ_s;
   logic [1:0] wrD;
   logic zeroHist [128];

   // reference model state
   logic [1:0] board [2][8][8];
   int pcLeft, plLeft;
   logic modelLastHit;

   // environment board storage, written only here
   logic [1:0] mem [2][8][8];
   logic doInit = 1'b0;

   always #5 clk = ~clk;

   turn_controller #(.BOARD_N(N), .PC_DELAY(D), .MAX_RETRY(R)) dut (
      .clk_i(clk), .rst_i(rst),
      .player_turn_State_i(playerTurnState), .pc_turn_State_i(pcTurnState),
      .fire_button_i(fireButton),
      .i_actual_i(iActual), .j_actual_i(jActual),
      .i_random_i(iRandom), .j_random_i(jRandom),
      .ship_amount_define_i(shipAmount), .load_counts_i(loadCounts),
      .rd_board_o(rdBoard), .rd_i_o(rdI), .rd_j_o(rdJ), .rd_data_i(rdData),
      .wr_en_o(wrEn), .wr_board_o(wrBoard), .wr_i_o(wrI), .wr_j_o(wrJ), .wr_data_o(wrData),
      .player_has_move_o(playerHasMove), .pc_has_move_o(pcHasMove),
      .pc_ships_zero_o(pcShipsZero), .player_ships_zero_o(playerShipsZero),
      .pc_ships_left_o(pcShipsLeft), .player_ships_left_o(playerShipsLeft),
      .last_hit_o(lastHit), .shot_rejected_o(shotRejected), .busy_o(busy)
   );

   assign allOut = {rdBoard, rdI, rdJ, wrEn, wrBoard, wrI, wrJ, wrData, playerHasMove, pcHasMove,
                    pcShipsZero, playerShipsZero, pcShipsLeft, playerShipsLeft, lastHit, shotRejected, busy};

   // board storage: registered read port, write port fed by the DUT
   always @(posedge clk) begin
      rdData <= mem[rdBoard][rdI][rdJ];
      if (doInit) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 8; i++)
               for (int j = 0; j < 8; j++)
                  mem[b][i][j] <= board[b][i][j];
      end else if (wrEn) begin
         mem[wrBoard][wrI][wrJ] <= wrData;
      end
   end

   task automatic syncBoard();
      @(negedge clk); doInit = 1'b1;
      @(negedge clk); doInit = 1'b0;
   endtask

   task automatic clearBoard(input int side);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            board[side][i][j] = 2'b00;
   endtask

   task automatic randomBoard(input int side, input int shotPct);
      clearBoard(side);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if ($urandom_range(0, 99) < shotPct) board[side][i][j] = 2'($urandom_range(2, 3));
            else board[side][i][j] = 2'($urandom_range(0, 1));
   endtask

   task automatic observe(input int n);
      wrCount = 0; pmCount = 0; pcmCount = 0; rejCount = 0;
      wrCycle = -1; pmCycle = -1; pcmCycle = -1;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); @(negedge clk);
         if (wrEn === 1'b1) begin
            wrCount++; wrCycle = c; wrB = wrBoard; wrI_s = wrI; wrJ_s = wrJ; wrD = wrData;
         end
         if (playerHasMove === 1'b1) begin pmCount++; pmCycle = c; end
         if (pcHasMove === 1'b1) begin pcmCount++; pcmCycle = c; end
         if (shotRejected === 1'b1) rejCount++;
         if (c < 128) zeroHist[c] = pcShipsZero;
      end
   endtask

   task automatic doLoad(input logic [2:0] n);
      @(negedge clk); shipAmount = n; loadCounts = 1'b1;
      @(posedge clk); @(negedge clk); loadCounts = 1'b0;
      pcLeft = (n > 5) ? 5 : int'(n);
      plLeft = pcLeft;
   endtask

   task automatic fireAt(input logic [2:0] i, input logic [2:0] j);
      @(negedge clk); playerTurnState = 1'b1; pcTurnState = 1'b0;
      iActual = i; jActual = j; fireButton = 1'b1;
      observe(8);
      fireButton = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic runPcTurn(input logic [2:0] ri, input logic [2:0] rj, input int n);
      @(negedge clk); playerTurnState = 1'b0; iRandom = ri; jRandom = rj; pcTurnState = 1'b1;
      observe(n);
      pcTurnState = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   // Number of rejected evaluations before the one that ends the PC turn.
   function automatic int pcPredict(input logic [2:0] ri, input logic [2:0] rj,
                                    output bit wrote, output int wi, output int wj);
      wrote = 1'b0; wi = 0; wj = 0;
      if (ri < N && rj < N && board[0][ri][rj][1] == 1'b0) begin
         wrote = 1'b1; wi = int'(ri); wj = int'(rj);
         return 0;
      end
      for (int k = 0; k < N * N; k++)
         if (board[0][k / N][k % N][1] == 1'b0) begin
            wrote = 1'b1; wi = k / N; wj = k % N;
            return R + k;
         end
      return R + N * N - 1;
   endfunction

   task automatic test_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      vectors++; if (allOut !== 30'd0) begin miscompares++; $display("[TB] FAIL reset_outputs: got %h expected 0", allOut); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (allOut !== 30'd0) begin miscompares++; $display("[TB] FAIL idle_after_reset: got %h expected 0", allOut); end
      pcLeft = 0; plLeft = 0; modelLastHit = 1'b0;
   endtask

   task automatic test_load();
      doLoad(3'd7);
      vectors++; if (pcShipsLeft !== 3'd5 || playerShipsLeft !== 3'd5) begin miscompares++; $display("[TB] FAIL load_clamp: got %0d/%0d expected 5/5", pcShipsLeft, playerShipsLeft); end
      doLoad(3'd0);
      @(posedge clk); @(negedge clk);
      vectors++; if ({pcShipsZero, playerShipsZero} !== 2'b11) begin miscompares++; $display("[TB] FAIL load_zero: got %b expected 11", {pcShipsZero, playerShipsZero}); end
   endtask

   task automatic test_player_hit();
      doLoad(3'd3);
      clearBoard(1); board[1][2][3] = 2'b01; syncBoard();
      fireAt(3'd2, 3'd3);
      vectors++; if (wrCount !== 1 || wrCycle !== 3) begin miscompares++; $display("[TB] FAIL phit_wr_timing: got count %0d cycle %0d expected 1/3", wrCount, wrCycle); end
      vectors++; if ({wrB, wrI_s, wrJ_s, wrD} !== {1'b1, 3'd2, 3'd3, 2'b11}) begin miscompares++; $display("[TB] FAIL phit_wr_fields: got %b expected 1_010_011_11", {wrB, wrI_s, wrJ_s, wrD}); end
      vectors++; if (pmCount !== 1 || pmCycle !== 4) begin miscompares++; $display("[TB] FAIL phit_move: got count %0d cycle %0d expected 1/4", pmCount, pmCycle); end
      vectors++; if (pcShipsLeft !== 3'd2 || lastHit !== 1'b1) begin miscompares++; $display("[TB] FAIL phit_state: got left %0d hit %b expected 2/1", pcShipsLeft, lastHit); end
      board[1][2][3] = 2'b11; pcLeft = 2; modelLastHit = 1'b1;
   endtask

   task automatic test_player_reject();
      board[1][0][0] = 2'b10; syncBoard();
      fireAt(3'd0, 3'd0);
      vectors++; if ({rejCount, wrCount, pmCount} !== {32'd1, 32'd0, 32'd0}) begin miscompares++; $display("[TB] FAIL rej_shot_cell: got rej %0d wr %0d mv %0d expected 1/0/0", rejCount, wrCount, pmCount); end
      fireAt(3'd5, 3'd1);
      vectors++; if ({rejCount, wrCount, pmCount} !== {32'd1, 32'd0, 32'd0}) begin miscompares++; $display("[TB] FAIL rej_range: got rej %0d wr %0d mv %0d expected 1/0/0", rejCount, wrCount, pmCount); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rej_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_player_random();
      logic [2:0] i, j;
      logic expRej, expHit;
      doLoad(3'd5);
      randomBoard(1, 40); syncBoard();
      for (int t = 0; t < 16; t++) begin
         i = 3'($urandom_range(0, 6)); j = 3'($urandom_range(0, 6));
         expRej = (i >= N) || (j >= N) || board[1][i][j][1];
         expHit = !expRej && (board[1][i][j] == 2'b01);
         fireAt(i, j);
         vectors++; if (rejCount !== int'(expRej) || wrCount !== int'(!expRej) || pmCount !== int'(!expRej)) begin
            miscompares++; $display("[TB] FAIL prand_outcome(%0d,%0d): got rej %0d wr %0d mv %0d expected rej %b", i, j, rejCount, wrCount, pmCount, expRej);
         end
         if (!expRej) begin
            vectors++; if ({wrB, wrI_s, wrJ_s, wrD} !== {1'b1, i, j, 1'b1, expHit} || wrCycle !== 3 || pmCycle !== 4) begin
               miscompares++; $display("[TB] FAIL prand_write(%0d,%0d): got %b at %0d/%0d expected %b at 3/4", i, j, {wrB, wrI_s, wrJ_s, wrD}, wrCycle, pmCycle, {1'b1, i, j, 1'b1, expHit});
            end
            board[1][i][j] = {1'b1, expHit};
            if (expHit && pcLeft > 0) pcLeft--;
            modelLastHit = expHit;
         end
         vectors++; if (pcShipsLeft !== 3'(pcLeft) || lastHit !== modelLastHit) begin
            miscompares++; $display("[TB] FAIL prand_state: got left %0d hit %b expected %0d/%b", pcShipsLeft, lastHit, pcLeft, modelLastHit);
         end
      end
   endtask

   task automatic test_pc_hit();
      doLoad(3'd4);
      clearBoard(0); board[0][1][1] = 2'b01; syncBoard();
      @(negedge clk); playerTurnState = 1'b0; iRandom = 3'd1; jRandom = 3'd1; pcTurnState = 1'b1;
      observe(20);
      vectors++; if (pcmCount !== 1 || pcmCycle !== D + 3) begin miscompares++; $display("[TB] FAIL pchit_move: got count %0d cycle %0d expected 1/%0d", pcmCount, pcmCycle, D + 3); end
      vectors++; if (wrCycle !== D + 2 || {wrB, wrI_s, wrJ_s, wrD} !== {1'b0, 3'd1, 3'd1, 2'b11}) begin miscompares++; $display("[TB] FAIL pchit_write: got %b at %0d expected 0_001_001_11 at %0d", {wrB, wrI_s, wrJ_s, wrD}, wrCycle, D + 2); end
      vectors++; if (playerShipsLeft !== 3'd3 || lastHit !== 1'b1) begin miscompares++; $display("[TB] FAIL pchit_state: got left %0d hit %b expected 3/1", playerShipsLeft, lastHit); end
      board[0][1][1] = 2'b11; plLeft = 3; modelLastHit = 1'b1;
      // turn still asserted: already served, and a fire request must be ignored
      playerTurnState = 1'b1; fireButton = 1'b1;
      observe(20);
      vectors++; if ({wrCount, pcmCount, pmCount, rejCount} !== 128'd0) begin miscompares++; $display("[TB] FAIL pc_served_ignore: got wr %0d pcmv %0d mv %0d rej %0d expected all 0", wrCount, pcmCount, pmCount, rejCount); end
      fireButton = 1'b0; pcTurnState = 1'b0; playerTurnState = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_pc_scan();
      int k;
      randomBoard(0, 100); board[0][0][4] = 2'b00; board[0][2][2] = 2'b10; syncBoard();
      runPcTurn(3'd2, 3'd2, 40);
      k = R + 4;
      vectors++; if (wrCount !== 1 || wrCycle !== D + 2 + 2 * k || {wrB, wrI_s, wrJ_s, wrD} !== {1'b0, 3'd0, 3'd4, 2'b10}) begin
         miscompares++; $display("[TB] FAIL pcscan_write: got %b at %0d (n=%0d) expected 0_000_100_10 at %0d", {wrB, wrI_s, wrJ_s, wrD}, wrCycle, wrCount, D + 2 + 2 * k);
      end
      vectors++; if (pcmCount !== 1 || pcmCycle !== D + 3 + 2 * k) begin miscompares++; $display("[TB] FAIL pcscan_move: got count %0d cycle %0d expected 1/%0d", pcmCount, pcmCycle, D + 3 + 2 * k); end
      board[0][0][4] = 2'b10; modelLastHit = 1'b0;
   endtask

   task automatic test_pc_random();
      logic [2:0] ri, rj;
      bit wrote, hit;
      int wi, wj, k;
      doLoad(3'd5);
      for (int t = 0; t < 12; t++) begin
         randomBoard(0, (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 90 : 40));
         syncBoard();
         ri = 3'($urandom_range(0, 6)); rj = 3'($urandom_range(0, 6));
         k = pcPredict(ri, rj, wrote, wi, wj);
         hit = wrote && (board[0][wi][wj] == 2'b01);
         runPcTurn(ri, rj, 75);
         vectors++; if (pcmCount !== 1 || pcmCycle !== D + 3 + 2 * k || rejCount !== 0) begin
            miscompares++; $display("[TB] FAIL pcrand_move(%0d,%0d): got count %0d cycle %0d rej %0d expected 1/%0d/0", ri, rj, pcmCount, pcmCycle, rejCount, D + 3 + 2 * k);
         end
         vectors++; if (wrCount !== int'(wrote)) begin miscompares++; $display("[TB] FAIL pcrand_wrcount: got %0d expected %0d", wrCount, wrote); end
         if (wrote) begin
            vectors++; if (wrCycle !== D + 2 + 2 * k || {wrB, wrI_s, wrJ_s, wrD} !== {1'b0, 3'(wi), 3'(wj), 1'b1, hit}) begin
               miscompares++; $display("[TB] FAIL pcrand_write: got %b at %0d expected %b at %0d", {wrB, wrI_s, wrJ_s, wrD}, wrCycle, {1'b0, 3'(wi), 3'(wj), 1'b1, hit}, D + 2 + 2 * k);
            end
            if (hit && plLeft > 0) plLeft--;
            modelLastHit = hit;
         end
         vectors++; if (playerShipsLeft !== 3'(plLeft) || lastHit !== modelLastHit) begin
            miscompares++; $display("[TB] FAIL pcrand_state: got left %0d hit %b expected %0d/%b", playerShipsLeft, lastHit, plLeft, modelLastHit);
         end
      end
   endtask

   task automatic test_ships_zero();
      doLoad(3'd1);
      clearBoard(1); board[1][3][3] = 2'b01; syncBoard();
      fireAt(3'd3, 3'd3);
      vectors++; if (wrCycle !== 3 || zeroHist[3] !== 1'b0 || zeroHist[4] !== 1'b1) begin
         miscompares++; $display("[TB] FAIL zero_timing: got wr %0d zero@3 %b zero@4 %b expected 3/0/1", wrCycle, zeroHist[3], zeroHist[4]);
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      vectors++; if ({pcShipsZero, playerShipsZero} !== 2'b10) begin miscompares++; $display("[TB] FAIL zero_hold: got %b expected 10", {pcShipsZero, playerShipsZero}); end
      doLoad(3'd2);
      @(posedge clk); @(negedge clk);
      vectors++; if (pcShipsZero !== 1'b0 || pcShipsLeft !== 3'd2) begin miscompares++; $display("[TB] FAIL zero_reload: got zero %b left %0d expected 0/2", pcShipsZero, pcShipsLeft); end
   endtask

   task automatic test_reset_mid();
      doLoad(3'd3);
      clearBoard(1); board[1][1][2] = 2'b00; syncBoard();
      @(negedge clk); playerTurnState = 1'b1; pcTurnState = 1'b0;
      iActual = 3'd1; jActual = 3'd2; fireButton = 1'b1;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b expected 1", busy); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      vectors++; if (allOut !== 30'd0) begin miscompares++; $display("[TB] FAIL rstmid_outputs: got %h expected 0", allOut); end
      rst = 1'b0;
      observe(10);
      vectors++; if ({wrCount, pmCount, rejCount} !== 96'd0 || busy !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rstmid_held_fire: got wr %0d mv %0d rej %0d busy %b expected 0", wrCount, pmCount, rejCount, busy);
      end
      fireButton = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; playerTurnState = 1'b0; pcTurnState = 1'b0; fireButton = 1'b0; loadCounts = 1'b0;
      iActual = 3'd0; jActual = 3'd0; iRandom = 3'd0; jRandom = 3'd0; shipAmount = 3'd0;
      clearBoard(0); clearBoard(1);
      test_reset();
      syncBoard();
      test_load();
      test_player_hit();
      test_player_reject();
      test_player_random();
      test_pc_hit();
      test_pc_scan();
      test_pc_random();
      test_ships_zero();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
Sequences the attack phase of the game on the two 5x5 boards (2-bit cells). On a player fire request, or on entry to the PC turn, it reads the target cell through the board read port, classifies the shot, writes back the hit/miss marker and decrements the defender's ship counter. It emits the single-cycle move-done strobes and ship-zero levels consumed by the game FSM. Sits between FSMgame, the board storage (tablero) and random_generator, and feeds the ships-left 7-segment decoders.

Parameters:
BOARD_N, 5, board dimension; valid coordinates are 0..BOARD_N-1
PC_DELAY, 8, clk cycles the PC "thinks" before sampling random coordinates (>=1)
MAX_RETRY, 4, random samples rejected before switching to raster scan

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
player_turn_State  in  1  FSM one-hot: player turn
pc_turn_State  in  1  FSM one-hot: PC turn
fire_button  in  1  player fire request, level; rising edge used
i_actual, j_actual  in  3 each  player cursor row/col
i_random, j_random  in  3 each  PC random row/col
ship_amount_define  in  3  ship count per side (1..5)
load_counts  in  1  pulse: load both ship counters
rd_board  out  1  0 = player board, 1 = PC board
rd_i, rd_j  out  3 each  read address
rd_data  in  2  cell contents, valid 1 cycle after address
wr_en  out  1  write strobe, one cycle
wr_board, wr_i, wr_j  out  1/3/3  write target
wr_data  out  2  value written
player_has_move  out  1  1-cycle pulse: player shot done
pc_has_move  out  1  1-cycle pulse: PC shot done
pc_ships_zero, player_ships_zero  out  1 each  level: counter == 0 after a load
pc_ships_left, player_ships_left  out  3 each  remaining ships
last_hit  out  1  result of most recent completed shot
shot_rejected  out  1  1-cycle pulse: player fired on invalid or already-shot cell
busy  out  1  FSM not in IDLE

Behaviour:
- Cell encoding: 00 water, 01 ship, 10 miss, 11 hit. Ships occupy one cell each.
- Reset (sync, rst=1 at a clk edge): state IDLE; counters=0; loaded flag=0; all outputs 0. Internal fire_prev is set to 1, so a button held through reset does not fire.
- fire_edge = fire_button & ~fire_prev, registered each cycle.
- States: IDLE, P_READ, P_EVAL, P_DONE, PC_WAIT, PC_READ, PC_EVAL, PC_DONE.
- IDLE, player path:
  - Requires player_turn_State & fire_edge.
  - Coordinates >= BOARD_N: pulse shot_rejected, remain in IDLE.
  - Otherwise latch i_actual/j_actual, set rd_board=1, go to P_READ.
- P_READ: address held; next state P_EVAL (rd_data valid there).
- P_EVAL:
  - 01: wr 11, pc_ships_left-1 (saturating at 0), last_hit=1, go to P_DONE.
  - 00: wr 10, last_hit=0, go to P_DONE.
  - 10/11: no write, pulse shot_rejected, return to IDLE with no move.
- P_DONE: player_has_move=1 for this cycle only; go to IDLE.
- IDLE, PC path: pc_turn_State and not already served this turn. Go to PC_WAIT and load the delay counter with PC_DELAY-1. A served flag is set at PC_DONE and cleared when pc_turn_State=0.
- PC_WAIT: decrement the delay counter. At 0, go to PC_READ with rd_board=0, address = i_random/j_random, retry=0.
- PC_READ: address presented; next state PC_EVAL.
- PC_EVAL:
  - 00 or 01: write 10/11 respectively, decrement player_ships_left on a hit, go to PC_DONE.
  - 10/11, or random coordinates out of range:
    - Not in scan mode: retry+1. If retry reaches MAX_RETRY, enter scan mode at (0,0); otherwise resample i_random/j_random. Either way return to PC_READ.
    - In scan mode: advance raster order (j+1, wrap to next i). If the scan passes (BOARD_N-1, BOARD_N-1) with no candidate, go to PC_DONE with no write; the PC move still completes.
- PC_DONE: pc_has_move pulse; go to IDLE.
- Total latency: player fire edge to player_has_move = 4 cycles. PC with first sample valid = PC_DELAY+3 cycles from entry to pc_has_move.
- Counters: load_counts sets both to min(ship_amount_define,5) and sets the loaded flag. load_counts overrides a same-cycle decrement and does not alter FSM state. *_ships_zero = loaded & (counter==0).
- Fire while pc_turn_State=1, or while busy: ignored, no shot_rejected.
- A turn signal dropping mid-sequence does not abort; the sequence completes atomically.
- rst mid-sequence: any pending write is dropped (wr_en=0 in the cycle after the rst edge) and state returns to IDLE.

Test Plan:
- Load 3 ships; PC cell (2,3)=01. player_turn=1, fire edge at cursor (2,3) -> wr_en with board=1, (2,3), data 11 on cycle 3; pc_ships_left=2; last_hit=1; player_has_move pulse on cycle 4.
- Fire at cell holding 10, then at cursor (5,1) -> shot_rejected pulses, no wr_en, no player_has_move, state IDLE.
- PC_DELAY=8; random (1,1) holds 01 -> pc_has_move 11 cycles after entry; player_ships_left decrements; player board (1,1)=11.
- Random always returns an already-shot cell; player board has only (0,4)=00 -> after 4 retries the scan writes 10 at (0,4), then pc_has_move.
- Load 1 ship; player sinks it -> pc_ships_zero=1 on the cycle after the write, stays high until load_counts/rst.
- Assert rst during P_EVAL -> no wr_en next cycle; all outputs 0; a held fire_button produces no shot after rst deasserts.
